// File: rtl/rescale_line_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rescale_line_buffer_if                                 |
// | Description : AXI-Stream pixel bus feeding the rescale line buffer.  |
// |               The master drives data/valid/last; the slave (line     |
// |               buffer) drives ready.                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface rescale_line_buffer_if;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic        S_AXIS_TLAST;

  modport master (
    output S_AXIS_TDATA,
    output S_AXIS_TVALID,
    output S_AXIS_TLAST,
    input  S_AXIS_TREADY
  );

  modport slave (
    input  S_AXIS_TDATA,
    input  S_AXIS_TVALID,
    input  S_AXIS_TLAST,
    output S_AXIS_TREADY
  );
endinterface
`default_nettype wire

// File: rtl/rescale_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rescale_line_buffer                                    |
// | Description : Two-row source window for the rescale core. Accepts    |
// |               the source frame over AXI-Stream into row-parity banks |
// |               and answers row requests with buffer_done, serving the |
// |               four bilinear neighbours of a requested column.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rescale_line_buffer #(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240,
  parameter int PIX_W = 16
) (
  input  wire                  CLOCK,
  input  wire                  RESETN,
  input  wire                  frame_start,
  rescale_line_buffer_if.slave s_axis,
  input  wire                  in_stream_ready,
  input  wire  [8:0]           row_to_wait,
  input  wire                  skip,
  output logic                 buffer_done,
  input  wire  [10:0]          neighbor_offset,
  output logic [15:0]          neighbor0,
  output logic [15:0]          neighbor1,
  output logic [15:0]          neighbor2,
  output logic [15:0]          neighbor3,
  output logic [8:0]           rows_stored,
  output logic                 frame_error
);

  localparam int            CW          = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam logic [8:0]    LAST_ROW    = 9'(SRC_H - 1);
  localparam logic [CW-1:0] LAST_COL    = CW'(SRC_W - 1);
  localparam logic [10:0]   LAST_COL_11 = 11'(SRC_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [8:0]      rows_q, rows_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [15:0]     n0_q, n1_q, n2_q, n3_q;
  logic [15:0]     n0_d, n1_d, n2_d, n3_d;

  // Row-parity banks: even rows live in bank0, odd rows in bank1.
  logic [PIX_W-1:0] bank0 [SRC_W];
  logic [PIX_W-1:0] bank1 [SRC_W];

  logic [8:0]      r_eff, r_bot;
  logic [9:0]      need;
  logic [10:0]     c_eff, c1;
  logic            satisfied, satisfied_next;
  logic            tready, xfer, row_done_now, exp_last;
  logic            unused_bits;

  // Clamp the requested row/column into the frame and derive the fill target.
  always_comb begin
    r_eff     = (row_to_wait > LAST_ROW) ? LAST_ROW : row_to_wait;
    r_bot     = (r_eff == LAST_ROW) ? LAST_ROW : r_eff + 9'd1;
    need      = {1'b0, r_bot} + 10'd1;
    satisfied = ({1'b0, rows_q} >= need);
    c_eff     = (neighbor_offset > LAST_COL_11) ? LAST_COL_11 : neighbor_offset;
    c1        = (c_eff == LAST_COL_11) ? LAST_COL_11 : c_eff + 11'd1;
  end

  // Accept beats only while filling and only up to the bottom requested row,
  // so row r_eff can never be overwritten by row r_eff+2.
  assign tready         = (state_q == S_FILL) && (rows_q <= r_bot) && !frame_start;
  assign xfer           = s_axis.S_AXIS_TVALID && tready;
  assign row_done_now   = xfer && (col_q == LAST_COL);
  assign satisfied_next = (({1'b0, rows_q} + {9'd0, row_done_now}) >= need);
  assign exp_last       = (rows_q == LAST_ROW) && (col_q == LAST_COL);

  // Request FSM next state; buffer_done follows one cycle after READY entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_stream_ready) state_d = (skip || satisfied) ? S_READY : S_FILL;
      end
      S_FILL: begin
        if (!in_stream_ready)    state_d = S_IDLE;
        else if (satisfied_next) state_d = S_READY;
      end
      S_READY: begin
        if (!in_stream_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_start) state_d = S_IDLE;
    done_d = (state_q == S_READY) && (state_d == S_READY);
  end

  // Write pointer, completed-row count and sticky TLAST check.
  always_comb begin
    col_d  = col_q;
    rows_d = rows_q;
    err_d  = err_q;
    if (frame_start) begin
      col_d  = '0;
      rows_d = '0;
      err_d  = 1'b0;
    end else if (xfer) begin
      if (col_q == LAST_COL) begin
        col_d  = '0;
        rows_d = rows_q + 9'd1;
      end else begin
        col_d = col_q + CW'(1);
      end
      if (s_axis.S_AXIS_TLAST != exp_last) err_d = 1'b1;
    end
  end

  // Neighbour fetch: top pair from bank r_eff[0], bottom pair from bank r_bot[0].
  always_comb begin
    n0_d = 16'(r_eff[0] ? bank1[c_eff[CW-1:0]] : bank0[c_eff[CW-1:0]]);
    n1_d = 16'(r_eff[0] ? bank1[c1[CW-1:0]]    : bank0[c1[CW-1:0]]);
    n2_d = 16'(r_bot[0] ? bank1[c_eff[CW-1:0]] : bank0[c_eff[CW-1:0]]);
    n3_d = 16'(r_bot[0] ? bank1[c1[CW-1:0]]    : bank0[c1[CW-1:0]]);
  end

  // Pixel storage is never cleared; a new frame simply overwrites it.
  always_ff @(posedge CLOCK) begin
    if (xfer && !rows_q[0]) bank0[col_q] <= s_axis.S_AXIS_TDATA[PIX_W-1:0];
    if (xfer &&  rows_q[0]) bank1[col_q] <= s_axis.S_AXIS_TDATA[PIX_W-1:0];
  end

  // Control and output registers with asynchronous abort.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      rows_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      n0_q    <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      n3_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      err_q   <= err_d;
      done_q  <= done_d;
      n0_q    <= n0_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      n3_q    <= n3_d;
    end
  end

  assign s_axis.S_AXIS_TREADY = tready;
  assign buffer_done          = done_q;
  assign rows_stored          = rows_q;
  assign frame_error          = err_q;
  assign neighbor0            = n0_q;
  assign neighbor1            = n1_q;
  assign neighbor2            = n2_q;
  assign neighbor3            = n3_q;

  // Upper data bits and clamped-column high bits carry no information.
  assign unused_bits = ^{s_axis.S_AXIS_TDATA[31:PIX_W], c_eff[10:CW], c1[10:CW]};

endmodule
`default_nettype wire

// File: doc/rescale_line_buffer.md
Name: rescale_line_buffer

Overview:
- Input-side responder for the rescale core: consumes the source frame from an AXI-Stream slave, keeps a two-row window in row-parity banks, and answers the core's row requests (in_stream_ready/row_to_wait/skip -> buffer_done).
- Serves four bilinear neighbours per column offset.
- Sits between the S_IN_AXIS slave interface and the rescale core's input port.

Parameters:
SRC_W, 320, source pixels per row
SRC_H, 240, source rows per frame
PIX_W, 16, pixel width (RGB565)

Ports:
CLOCK  in  1  system clock, rising edge
RESETN  in  1  asynchronous active-low reset
frame_start  in  1  sync pulse: clear row counters/state for new frame (storage contents not cleared)
S_AXIS_TDATA  in  32  pixel in [PIX_W-1:0], upper bits ignored
S_AXIS_TVALID  in  1  stream valid
S_AXIS_TREADY  out  1  stream ready
S_AXIS_TLAST  in  1  last pixel of frame
in_stream_ready  in  1  core requests rows; level, held until buffer_done seen
row_to_wait  in  9  requested top source row r
skip  in  1  requested rows already resident; no stream consumption
buffer_done  out  1  requested rows r and r+1 (clamped) resident
neighbor_offset  in  11  source column c
neighbor0  out  16  pixel(r, c)
neighbor1  out  16  pixel(r, c+1 clamped)
neighbor2  out  16  pixel(r+1 clamped, c)
neighbor3  out  16  pixel(r+1 clamped, c+1 clamped)
rows_stored  out  9  complete rows received this frame
frame_error  out  1  sticky TLAST mismatch flag

Behaviour:
- Reset (RESETN=0, async): state IDLE; TREADY, buffer_done, frame_error = 0; rows_stored, column counter = 0; neighbour regs = 0.
- frame_start: sync clear of rows_stored, column counter, frame_error; state -> IDLE. Has priority over all other events in the same cycle.
- Storage: two banks of SRC_W x PIX_W. Row k is written to bank k[0].
- Write pointer: column counter 0..SRC_W-1. Wraps at SRC_W-1, then rows_stored increments. Saturates at SRC_H; no TREADY once rows_stored = SRC_H.
- Clamping: r_eff = min(row_to_wait, SRC_H-1); r_bot = min(r_eff+1, SRC_H-1); need = r_bot+1; satisfied = rows_stored >= need.
- TREADY = (state == FILL) && (row currently being received <= r_bot). This prevents overwriting row r_eff. Rows < r_eff are accepted and later overwritten (discard on downscale).
- Transfer: occurs when TVALID && TREADY.
- TLAST check: TLAST must be 1 exactly on pixel (SRC_H-1, SRC_W-1). Any mismatch sets frame_error (sticky); the pixel is still stored.
- FSM:
  - IDLE: in_stream_ready=1 -> READY if skip or satisfied, else FILL.
  - FILL: satisfied (including by the beat completing a row this cycle, evaluated next cycle) -> READY. in_stream_ready=0 -> IDLE; data kept, partial row continues later.
  - READY: buffer_done=1 (registered, asserted the cycle after entry). in_stream_ready=0 -> IDLE, buffer_done=0 the following cycle.
- Latency: skip or already satisfied -> buffer_done 2 cycles after in_stream_ready rises. FILL -> buffer_done 1 cycle after the final needed beat is written.
- Neighbour read: 1-cycle registered. Outputs reflect neighbor_offset and row_to_wait sampled on the previous edge.
  - c_eff = min(c, SRC_W-1); c1 = min(c_eff+1, SRC_W-1).
  - neighbor0/1 from bank r_eff[0]; neighbor2/3 from bank r_bot[0].
  - When r_eff = SRC_H-1, neighbor2 = neighbor0 and neighbor3 = neighbor1.
- Outputs valid only while buffer_done=1. The read path is independent of write activity.
- Reset mid-fill: abort immediately. The core must re-request after reset and frame_start.

Test Plan:
- SRC_W=4, SRC_H=3; stream 0x000..0x00B continuously, TLAST on 12th beat; request r=0 -> TREADY drops after 8 beats; buffer_done high 1 cycle after 8th beat; offset 3 -> n0=0x003, n1=0x003, n2=0x007, n3=0x007.
- Same frame, then request r=2 -> remaining 4 beats accepted; buffer_done; offset 1 -> n0=0x009, n1=0x00A, n2=0x009, n3=0x00A.
- Request r=1 with skip=1 after r=0 satisfied -> no TREADY; buffer_done exactly 2 cycles after in_stream_ready rises; offset 0 -> n0=0x004, n2=0x008.
- TLAST asserted on beat 5 -> frame_error=1, remains 1 until frame_start; data still stored; buffer_done still produced for r=0.
- Deassert in_stream_ready after 5 beats of r=0 fill -> IDLE, TREADY=0; re-request -> fill resumes at beat 6, buffer_done after beat 8.
- Assert RESETN=0 during FILL -> TREADY=0, buffer_done=0, rows_stored=0 in the same cycle (async).
